// File: rtl/coin_charger_ctrl_p.sv
// Coin charger control core: keypad money entry, money-to-time conversion,
// prescaled countdown while charging, and idle power-off.
// All button/key inputs pass through one sampling register before edge
// detection, so an input sampled at edge n changes outputs at edge n+1.
module coin_charger_ctrl_p #(
  parameter int         MONEY_W      = 8,
  parameter int         TIMER_W      = 8,
  parameter int         DIGITS       = 2,
  parameter int         MAX_MONEY    = 20,
  parameter int         RATE         = 2,
  parameter int         TICK_DIV     = 1000,
  parameter int         IDLE_TIMEOUT = 10,
  parameter logic [3:0] NO_KEY       = 4'hF
) (
  input  logic               CLK,
  input  logic               rst,
  input  logic [3:0]         data,
  input  logic               start,
  input  logic               reset,
  input  logic               ok,
  output logic [MONEY_W-1:0] money,
  output logic [TIMER_W-1:0] timer,
  output logic [3:0]         state_viewer,
  output logic               charging,
  output logic               overflow
);

  localparam int PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IW    = $clog2(IDLE_TIMEOUT + 1);
  localparam int DW    = $clog2(DIGITS + 1);
  localparam int PRODW = MONEY_W + 4;
  localparam int TPW   = MONEY_W + 32;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_OFF    = 2'd0,
    S_INPUT  = 2'd1,
    S_CHARGE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [MONEY_W-1:0] money_q, money_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               charging_q, charging_d;
  logic               overflow_q, overflow_d;
  logic [PW-1:0]      presc_q, presc_d;
  logic [IW-1:0]      idle_q, idle_d;
  logic [DW-1:0]      dcnt_q, dcnt_d;
  logic [3:0]         data_q, data_d, data_prev_q, data_prev_d;
  logic               start_q, start_d, start_prev_q, start_prev_d;
  logic               reset_q, reset_d, reset_prev_q, reset_prev_d;
  logic               ok_q, ok_d, ok_prev_q, ok_prev_d;

  logic               start_ev, reset_ev, ok_ev, digit_ev, any_ev, tick;
  logic [PRODW-1:0]   prod;
  logic [TPW-1:0]     tprod;
  logic [TIMER_W-1:0] timer_load;

  // Input sampling, event detection, and next-state / datapath update
  always_comb begin
    data_d       = data;
    start_d      = start;
    reset_d      = reset;
    ok_d         = ok;
    data_prev_d  = data_q;
    start_prev_d = start_q;
    reset_prev_d = reset_q;
    ok_prev_d    = ok_q;

    start_ev = start_q & ~start_prev_q;
    reset_ev = reset_q & ~reset_prev_q;
    ok_ev    = ok_q & ~ok_prev_q;
    digit_ev = (data_q <= 4'd9) && (data_q != data_prev_q);
    any_ev   = start_ev | reset_ev | ok_ev | digit_ev;
    tick     = (presc_q == PRESC_LAST);

    prod       = PRODW'(money_q) * PRODW'(10) + PRODW'(data_q);
    tprod      = TPW'(money_q) * TPW'(RATE);
    timer_load = (|tprod[TPW-1:TIMER_W]) ? '1 : tprod[TIMER_W-1:0];

    state_d    = state_q;
    money_d    = money_q;
    timer_d    = timer_q;
    overflow_d = 1'b0;
    presc_d    = presc_q;
    idle_d     = idle_q;
    dcnt_d     = dcnt_q;

    case (state_q)
      S_OFF: begin
        money_d = '0;
        timer_d = '0;
        presc_d = '0;
        idle_d  = '0;
        dcnt_d  = '0;
        if (start_ev) state_d = S_INPUT;
      end

      S_INPUT: begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        if (any_ev) begin
          idle_d = '0;
        end else if (tick) begin
          if (idle_q >= IW'(IDLE_TIMEOUT - 1)) begin
            idle_d  = IW'(IDLE_TIMEOUT);
            state_d = S_OFF;
            money_d = '0;
            dcnt_d  = '0;
            presc_d = '0;
          end else begin
            idle_d = idle_q + 1'b1;
          end
        end

        if (reset_ev) begin
          money_d = '0;
          dcnt_d  = '0;
        end else if (ok_ev) begin
          if (money_q != '0) begin
            state_d = S_CHARGE;
            timer_d = timer_load;
            presc_d = '0;
          end
        end else if (digit_ev && (dcnt_q < DW'(DIGITS))) begin
          dcnt_d = dcnt_q + 1'b1;
          if (prod > PRODW'(MAX_MONEY)) begin
            money_d    = MONEY_W'(MAX_MONEY);
            overflow_d = 1'b1;
          end else begin
            money_d = prod[MONEY_W-1:0];
          end
        end
      end

      S_CHARGE: begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        if (reset_ev) begin
          state_d = S_INPUT;
          money_d = '0;
          timer_d = '0;
          dcnt_d  = '0;
          presc_d = '0;
          idle_d  = '0;
        end else if (tick) begin
          timer_d = timer_q - 1'b1;
          if (timer_q == TIMER_W'(1)) state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_INPUT;
        money_d = '0;
        timer_d = '0;
        dcnt_d  = '0;
        idle_d  = '0;
        presc_d = '0;
      end

      default: state_d = S_OFF;
    endcase

    charging_d = (state_d == S_CHARGE);
  end

  // State and history registers; rst returns everything to the OFF picture.
  // Key history clears to NO_KEY so a '0' pressed right after reset still counts.
  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q      <= S_OFF;
      money_q      <= '0;
      timer_q      <= '0;
      charging_q   <= 1'b0;
      overflow_q   <= 1'b0;
      presc_q      <= '0;
      idle_q       <= '0;
      dcnt_q       <= '0;
      data_q       <= NO_KEY;
      data_prev_q  <= NO_KEY;
      start_q      <= 1'b0;
      start_prev_q <= 1'b0;
      reset_q      <= 1'b0;
      reset_prev_q <= 1'b0;
      ok_q         <= 1'b0;
      ok_prev_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      money_q      <= money_d;
      timer_q      <= timer_d;
      charging_q   <= charging_d;
      overflow_q   <= overflow_d;
      presc_q      <= presc_d;
      idle_q       <= idle_d;
      dcnt_q       <= dcnt_d;
      data_q       <= data_d;
      data_prev_q  <= data_prev_d;
      start_q      <= start_d;
      start_prev_q <= start_prev_d;
      reset_q      <= reset_d;
      reset_prev_q <= reset_prev_d;
      ok_q         <= ok_d;
      ok_prev_q    <= ok_prev_d;
    end
  end

  assign money        = money_q;
  assign timer        = timer_q;
  assign state_viewer = {2'b00, state_q};
  assign charging     = charging_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_coin_charger_ctrl_p.sv
// Directed bench for coin_charger_ctrl_p with TICK_DIV=4, IDLE_TIMEOUT=5.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_coin_charger_ctrl_p;

  logic       CLK;
  logic       rst;
  logic [3:0] data;
  logic       start;
  logic       reset;
  logic       ok;
  logic [7:0] money;
  logic [7:0] timer;
  logic [3:0] state_viewer;
  logic       charging;
  logic       overflow;

  int checks   = 0;
  int failures = 0;

  coin_charger_ctrl_p #(
    .MONEY_W(8), .TIMER_W(8), .DIGITS(2), .MAX_MONEY(20), .RATE(2),
    .TICK_DIV(4), .IDLE_TIMEOUT(5), .NO_KEY(4'hF)
  ) dut (
    .CLK(CLK), .rst(rst), .data(data), .start(start), .reset(reset), .ok(ok),
    .money(money), .timer(timer), .state_viewer(state_viewer),
    .charging(charging), .overflow(overflow)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // advance n cycles, confirming overflow stays low on each one
  task automatic run_q(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1);
      chk("no_ovf", {31'd0, overflow}, 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; reset = 1'b0; ok = 1'b0; data = 4'hF;
    cyc(2);
    chk("rst_state",    {28'd0, state_viewer}, 32'd0);
    chk("rst_money",    {24'd0, money}, 32'd0);
    chk("rst_timer",    {24'd0, timer}, 32'd0);
    chk("rst_charging", {31'd0, charging}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);

    // 1: start held 3 cycles -> one transition to INPUT
    rst = 1'b0; start = 1'b1;
    cyc(1); chk("t1_latency", {28'd0, state_viewer}, 32'd0);
    cyc(1); chk("t1_input",   {28'd0, state_viewer}, 32'd1);
    cyc(1); start = 1'b0;
    chk("t1_still_input", {28'd0, state_viewer}, 32'd1);
    chk("t1_money", {24'd0, money}, 32'd0);
    chk("t1_timer", {24'd0, timer}, 32'd0);

    // 2: held keys count once; third digit ignored
    data = 4'd1;
    cyc(1); chk("t2_lat_money", {24'd0, money}, 32'd0);
    cyc(1); chk("t2_money1",    {24'd0, money}, 32'd1);
    run_q(3); data = 4'hF;
    run_q(3); data = 4'd2;
    run_q(2); chk("t2_money12", {24'd0, money}, 32'd12);
    run_q(3); data = 4'hF;
    run_q(1); data = 4'd3;
    run_q(5); chk("t2_money_hold", {24'd0, money}, 32'd12);
    chk("t2_state", {28'd0, state_viewer}, 32'd1);

    // 3: clear, then 2,5 saturates at 20 with a single overflow pulse
    data = 4'hF; reset = 1'b1;
    cyc(1); reset = 1'b0;
    cyc(1); chk("t3_cleared", {24'd0, money}, 32'd0);
    data = 4'd2;
    cyc(2); chk("t3_money2", {24'd0, money}, 32'd2);
    data = 4'd5;
    cyc(1); chk("t3_ovf_pre", {31'd0, overflow}, 32'd0);
    cyc(1); chk("t3_money20", {24'd0, money}, 32'd20);
    chk("t3_ovf_pulse", {31'd0, overflow}, 32'd1);
    cyc(1); chk("t3_ovf_end", {31'd0, overflow}, 32'd0);
    data = 4'd7;
    cyc(2); chk("t3_extra_ignored", {24'd0, money}, 32'd20);
    chk("t3_extra_no_ovf", {31'd0, overflow}, 32'd0);
    cyc(1); chk("t3_extra_no_ovf2", {31'd0, overflow}, 32'd0);
    data = 4'hF;

    // 4: money 3 -> timer 6, countdown at 4 cycles per tick, DONE, back to INPUT
    reset = 1'b1;
    cyc(1); reset = 1'b0;
    cyc(1); chk("t4_cleared", {24'd0, money}, 32'd0);
    data = 4'd3;
    cyc(2); chk("t4_money3", {24'd0, money}, 32'd3);
    data = 4'hF; ok = 1'b1;
    cyc(1); chk("t4_lat_state", {28'd0, state_viewer}, 32'd1);
    cyc(1); chk("t4_charge",   {28'd0, state_viewer}, 32'd2);
    chk("t4_timer6",   {24'd0, timer}, 32'd6);
    chk("t4_charging", {31'd0, charging}, 32'd1);
    cyc(3); chk("t4_timer6_hold", {24'd0, timer}, 32'd6);
    ok = 1'b0;
    cyc(1); chk("t4_timer5", {24'd0, timer}, 32'd5);
    cyc(19); chk("t4_timer1", {24'd0, timer}, 32'd1);
    chk("t4_still_charge", {28'd0, state_viewer}, 32'd2);
    cyc(1); chk("t4_done", {28'd0, state_viewer}, 32'd3);
    chk("t4_timer0", {24'd0, timer}, 32'd0);
    chk("t4_done_nochg", {31'd0, charging}, 32'd0);
    cyc(1); chk("t4_back_input", {28'd0, state_viewer}, 32'd1);
    chk("t4_money_clr", {24'd0, money}, 32'd0);

    // 5: abort mid-charge; reset beats ok in the same cycle
    data = 4'd3;
    cyc(2); chk("t5_money3", {24'd0, money}, 32'd3);
    data = 4'hF; ok = 1'b1;
    cyc(1); ok = 1'b0;
    cyc(1); chk("t5_charge", {28'd0, state_viewer}, 32'd2);
    cyc(8); chk("t5_timer4", {24'd0, timer}, 32'd4);
    reset = 1'b1;
    cyc(1); reset = 1'b0;
    chk("t5_lat_state", {28'd0, state_viewer}, 32'd2);
    cyc(1); chk("t5_abort_state", {28'd0, state_viewer}, 32'd1);
    chk("t5_abort_money", {24'd0, money}, 32'd0);
    chk("t5_abort_timer", {24'd0, timer}, 32'd0);
    chk("t5_abort_chg",   {31'd0, charging}, 32'd0);
    data = 4'd4;
    cyc(2); chk("t5_money4", {24'd0, money}, 32'd4);
    data = 4'hF; reset = 1'b1; ok = 1'b1;
    cyc(1); reset = 1'b0; ok = 1'b0;
    cyc(1); chk("t5_prio_state", {28'd0, state_viewer}, 32'd1);
    chk("t5_prio_money", {24'd0, money}, 32'd0);

    // 6a: rst mid-charge
    data = 4'd5;
    cyc(2); chk("t6_money5", {24'd0, money}, 32'd5);
    data = 4'hF; ok = 1'b1;
    cyc(1); ok = 1'b0;
    cyc(1); chk("t6_timer10", {24'd0, timer}, 32'd10);
    cyc(5); chk("t6_timer9", {24'd0, timer}, 32'd9);
    rst = 1'b1;
    cyc(1);
    chk("t6_rst_state", {28'd0, state_viewer}, 32'd0);
    chk("t6_rst_money", {24'd0, money}, 32'd0);
    chk("t6_rst_timer", {24'd0, timer}, 32'd0);
    chk("t6_rst_chg",   {31'd0, charging}, 32'd0);
    chk("t6_rst_ovf",   {31'd0, overflow}, 32'd0);

    // 6b: idle timeout after 5 ticks in INPUT
    rst = 1'b0; start = 1'b1;
    cyc(1); start = 1'b0;
    cyc(1); chk("t6_input", {28'd0, state_viewer}, 32'd1);
    cyc(19); chk("t6_pre_timeout", {28'd0, state_viewer}, 32'd1);
    cyc(1); chk("t6_timeout_off", {28'd0, state_viewer}, 32'd0);
    chk("t6_off_money", {24'd0, money}, 32'd0);

    // OFF ignores digits and ok
    data = 4'd7;
    cyc(3); data = 4'hF; ok = 1'b1;
    cyc(3); ok = 1'b0;
    chk("off_ign_state", {28'd0, state_viewer}, 32'd0);
    chk("off_ign_money", {24'd0, money}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/coin_charger_ctrl_p.md
Name: coin_charger_ctrl_p

Overview:
Parametrised next-generation control core for the coin-operated charger. It takes keypad digits and the start/reset/ok buttons, builds a multi-digit money amount, converts it to charge time and counts that time down on a prescaled tick. It also powers the unit off after a period with no key activity. Its registered outputs drive the money/timer display path and the state_viewer debug LEDs.

Parameters:
MONEY_W, 8, width of money register; MAX_MONEY must be < 2^MONEY_W
TIMER_W, 8, width of timer register
DIGITS, 2, maximum number of digits accepted per entry
MAX_MONEY, 20, money saturation ceiling
RATE, 2, timer units granted per money unit
TICK_DIV, 1000, CLK cycles per tick (1 ms clock gives a 1 s tick)
IDLE_TIMEOUT, 10, ticks without an accepted event in INPUT before power-off
NO_KEY, 4'hF, data code meaning no key pressed

Ports:
CLK  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
data  in  4  keypad code; 0-9 are digits, NO_KEY means idle, any other value is ignored
start  in  1  power-on button, level, held for multiple cycles
reset  in  1  clear/abort button, level
ok  in  1  confirm button, level
money  out  MONEY_W  entered amount
timer  out  TIMER_W  remaining charge time in ticks
state_viewer  out  4  current state code
charging  out  1  high while in CHARGE
overflow  out  1  one-cycle pulse when a digit entry saturates at MAX_MONEY

Behaviour:
- Reset: rst high at a CLK edge forces state OFF, with money=0, timer=0, charging=0, overflow=0, prescaler=0, idle counter=0, digit count=0 and all edge-detect history cleared. rst overrides all other inputs, including mid-charge.
- Edge detection: start, reset and ok each produce a single event on the first cycle they are high after a low cycle. Holding a button generates no further events.
- Digit events: a digit event occurs when data is 0-9 and differs from the previous cycle's data, so a held key counts once. Codes 10-14 never produce events.
- Latency: all outputs are registered. An event sampled at edge n appears on the outputs after edge n+1.
- Priority within one cycle: reset > ok > digit. start only has an effect in OFF.
- State codes: OFF=0, INPUT=1, CHARGE=2, DONE=3.
- OFF:
  - money=0, timer=0.
  - A start event moves to INPUT. Digits, ok and reset are ignored.
- INPUT, digits:
  - A digit event with digit count < DIGITS sets money = min(money*10 + d, MAX_MONEY) and increments digit count.
  - The product is computed in MONEY_W+4 bits.
  - If the result is clipped, overflow pulses for one cycle.
  - A digit event with digit count = DIGITS is ignored: money unchanged, no overflow pulse.
- INPUT, reset event: money=0 and digit count=0; state stays INPUT.
- INPUT, ok event:
  - If money>0: go to CHARGE with timer = min(money*RATE, 2^TIMER_W-1) and prescaler cleared.
  - If money=0: ignored.
- INPUT, idle timeout:
  - The idle counter increments on each tick and clears on any event.
  - When it reaches IDLE_TIMEOUT, go to OFF.
  - The prescaler free-runs while in INPUT.
- CHARGE:
  - charging=1. Digits are ignored; money holds its value.
  - Each tick decrements timer. The first tick occurs TICK_DIV cycles after entry.
  - When timer goes from 1 to 0, go to DONE.
  - A reset event aborts: go to INPUT with money=0, timer=0, digit count=0.
  - ok events are ignored.
- DONE: lasts exactly one cycle with timer=0, then goes to INPUT with money=0, digit count=0 and idle counter=0.
- Prescaler: counts 0..TICK_DIV-1. A tick is asserted on the terminal count, then the prescaler wraps to 0.
- Idle counter: does not wrap; it saturates at IDLE_TIMEOUT.

Test Plan:
Bench parameters for all scenarios: TICK_DIV=4, IDLE_TIMEOUT=5, DIGITS=2, MAX_MONEY=20, RATE=2.
1. rst pulse, then start held 3 cycles -> state_viewer 0 then 1; exactly one transition; money=0, timer=0.
2. From INPUT, data=1 held 5 cycles, NO_KEY for 3, data=2 held 5, NO_KEY, data=3 held 5 -> money 1, then 12, then stays 12; overflow never asserted.
3. reset event, then digits 2 and 5 -> money 2, then 20; overflow high for exactly one cycle; a further digit is ignored.
4. reset, digit 3, ok held 5 cycles -> state 2, timer=6, charging=1. After 4 more cycles timer=5. Timer reaches 0 at cycle 24, DONE for one cycle, then INPUT with money=0.
5. money=3 charging, reset event when timer=4 -> next cycle state 1, money=0, timer=0, charging=0. A second reset and ok in the same cycle -> reset wins.
6. INPUT with no events for 5 ticks (20 cycles) -> state 0. Separately, rst asserted mid-CHARGE -> all outputs at reset values after the next edge.
